// File: rtl/prog_loader_if.sv
// Byte-stream input, memory write ports and boot status of the program loader.
// master: stream source / memory side; slave: the loader itself.
interface prog_loader_if #(
  parameter int unsigned INST_AW = 8,
  parameter int unsigned DATA_AW = 14
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               inst_we;
  logic [INST_AW-1:0] inst_addr;
  logic [31:0]        inst_wdata;
  logic               data_we;
  logic [DATA_AW-1:0] data_addr;
  logic [31:0]        data_wdata;
  logic               boot_done;
  logic               boot_err;
  logic               core_rstn_o;

  modport master (
    output in_valid, in_data,
    input  in_ready, inst_we, inst_addr, inst_wdata, data_we, data_addr, data_wdata,
    input  boot_done, boot_err, core_rstn_o
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, inst_we, inst_addr, inst_wdata, data_we, data_addr, data_wdata,
    output boot_done, boot_err, core_rstn_o
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream and writes the inst then data
// image; holds the CPU in reset until done. Define LOADER_CHECKSUM_EN for a trailing sum check.
module prog_loader #(
  parameter int unsigned INST_AW  = 8,
  parameter int unsigned DATA_AW  = 14,
  parameter logic [31:0] END_MARK = 32'hFFFFFFFF
) (
  input logic          clk,
  input logic          rstn,
  prog_loader_if.slave bus
);

  localparam logic [32:0]        DataDepth = 33'd1 << DATA_AW;
  localparam logic [INST_AW-1:0] InstLast  = '1;
  localparam logic [DATA_AW:0]   RemainOne = 1;

  typedef enum logic [2:0] {
    StInst = 3'd0,
    StDcnt = 3'd1,
    StData = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
`ifdef LOADER_CHECKSUM_EN
    , StCsum = 3'd5
`endif
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e             state_q, state_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        word_q, word_d;
  logic [INST_AW-1:0] inst_ptr_q, inst_ptr_d;
  logic [DATA_AW-1:0] data_ptr_q, data_ptr_d;
  logic [DATA_AW:0]   remain_q, remain_d;
  logic               in_ready_q, in_ready_d;
  logic               inst_we_q, inst_we_d;
  logic [INST_AW-1:0] inst_addr_q, inst_addr_d;
  logic [31:0]        inst_wdata_q, inst_wdata_d;
  logic               data_we_q, data_we_d;
  logic [DATA_AW-1:0] data_addr_q, data_addr_d;
  logic [31:0]        data_wdata_q, data_wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]        sum_q, sum_d;
`endif

  logic        xfer;
  logic [31:0] word_full;

  assign xfer      = bus.in_valid & in_ready_q;
  assign word_full = {word_q, bus.in_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StInst;
      bcnt_q       <= '0;
      word_q       <= '0;
      inst_ptr_q   <= '0;
      data_ptr_q   <= '0;
      remain_q     <= '0;
      in_ready_q   <= 1'b0;
      inst_we_q    <= 1'b0;
      inst_addr_q  <= '0;
      inst_wdata_q <= '0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      inst_ptr_q   <= inst_ptr_d;
      data_ptr_q   <= data_ptr_d;
      remain_q     <= remain_d;
      in_ready_q   <= in_ready_d;
      inst_we_q    <= inst_we_d;
      inst_addr_q  <= inst_addr_d;
      inst_wdata_q <= inst_wdata_d;
      data_we_q    <= data_we_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    word_d       = word_q;
    inst_ptr_d   = inst_ptr_q;
    data_ptr_d   = data_ptr_q;
    remain_d     = remain_q;
    inst_we_d    = 1'b0;
    inst_addr_d  = inst_addr_q;
    inst_wdata_d = inst_wdata_q;
    data_we_d    = 1'b0;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    // Status lags the state by one cycle so done follows the final write strobe.
    done_d       = done_q | (state_q == StDone);
    err_d        = err_q | (state_q == StErr);
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    if (xfer) begin
      bcnt_d = bcnt_q + 2'd1;
      word_d = word_full[23:0];
      if (bcnt_q == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
        if (state_q != StCsum) sum_d = sum_q + word_full;
`endif
        unique case (state_q)
          StInst: begin
            if ((word_full != END_MARK) && (inst_ptr_q == InstLast)) begin
              state_d = StErr;
            end else begin
              inst_we_d    = 1'b1;
              inst_addr_d  = inst_ptr_q;
              inst_wdata_d = word_full;
              inst_ptr_d   = inst_ptr_q + INST_AW'(1);
              if (word_full == END_MARK) state_d = StDcnt;
            end
          end
          StDcnt: begin
            if (word_full == 32'd0) begin
              state_d = StAfterData;
            end else if ({1'b0, word_full} > DataDepth) begin
              state_d = StErr;
            end else begin
              remain_d = word_full[DATA_AW:0];
              state_d  = StData;
            end
          end
          StData: begin
            data_we_d    = 1'b1;
            data_addr_d  = data_ptr_q;
            data_wdata_d = word_full;
            data_ptr_d   = data_ptr_q + DATA_AW'(1);
            remain_d     = remain_q - RemainOne;
            if (remain_q == RemainOne) state_d = StAfterData;
          end
`ifdef LOADER_CHECKSUM_EN
          StCsum: state_d = (word_full == sum_q) ? StDone : StErr;
`endif
          default: ;
        endcase
      end
    end

    in_ready_d = (state_d != StDone) && (state_d != StErr);
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.inst_we     = inst_we_q;
  assign bus.inst_addr   = inst_addr_q;
  assign bus.inst_wdata  = inst_wdata_q;
  assign bus.data_we     = data_we_q;
  assign bus.data_addr   = data_addr_q;
  assign bus.data_wdata  = data_wdata_q;
  assign bus.boot_done   = done_q;
  assign bus.boot_err    = err_q;
  assign bus.core_rstn_o = done_q;

endmodule
